// File: rtl/rv_pkg.sv
// Shared types for the load/store unit: op and exception encodings, FSM states, request payload.
package rv_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned REG_AW = 5;
    localparam int unsigned CNT_W  = 16;

    typedef enum logic [1:0] {
        OP_ILL0 = 2'b00,
        OP_LW   = 2'b01,
        OP_SW   = 2'b10,
        OP_ILL3 = 2'b11
    } lsu_op_e;

    typedef enum logic [1:0] {
        EXC_NONE     = 2'b00,
        EXC_MISALIGN = 2'b01,
        EXC_ILLEGAL  = 2'b10,
        EXC_TIMEOUT  = 2'b11
    } exc_cause_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_WAIT = 2'b10,
        ST_RESP = 2'b11
    } lsu_state_e;

    typedef struct packed {
        lsu_op_e           op;
        logic [XLEN-1:0]   addr;
        logic [XLEN-1:0]   wdata;
        logic [REG_AW-1:0] rd;
    } lsu_req_t;

    function automatic logic op_is_legal(input lsu_op_e op);
        return (op == OP_LW) || (op == OP_SW);
    endfunction

endpackage

// File: rtl/lsu_timeout_ctr.sv
// Load response watchdog: counts WAIT cycles; expired is high during the TIMEOUT_CYCLES-th cycle.
module lsu_timeout_ctr
    import rv_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_inc;
    logic             expired_q;

    assign cnt_inc = cnt_q + CNT_W'(1);
    assign expired = expired_q;

    // expired is precomputed one edge ahead so it is a registered flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            expired_q <= 1'b0;
        end else if (clear) begin
            cnt_q     <= '0;
            expired_q <= (TIMEOUT_CYCLES == 32'd1);
        end else if (enable) begin
            cnt_q     <= cnt_inc;
            expired_q <= (cnt_inc == CNT_W'(TIMEOUT_CYCLES - 32'd1));
        end
    end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit between the ALU stage and a req/gnt/rvalid data memory.
module load_store_unit
    import rv_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_op,
    input  logic [XLEN-1:0]   req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    input  logic [REG_AW-1:0] req_rd,
    output logic              mem_req,
    output logic              mem_we,
    output logic [XLEN-1:0]   mem_addr,
    output logic [XLEN-1:0]   mem_wdata,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [XLEN-1:0]   mem_rdata,
    output logic              wb_valid,
    output logic [REG_AW-1:0] wb_rd,
    output logic [XLEN-1:0]   wb_data,
    output logic              exc_valid,
    output logic [1:0]        exc_cause
);

    lsu_state_e        state_q, state_d;
    lsu_req_t          req_q, req_d;
    logic [XLEN-1:0]   rdata_q, rdata_d;
    logic              exc_d;
    exc_cause_e        cause_d;
    exc_cause_e        exc_cause_q;

    logic              req_ready_q;
    logic              mem_req_q, mem_we_q;
    logic [XLEN-1:0]   mem_addr_q, mem_wdata_q;
    logic              wb_valid_q;
    logic [REG_AW-1:0] wb_rd_q;
    logic [XLEN-1:0]   wb_data_q;
    logic              exc_valid_q;

    logic              accept_c;
    logic              ctr_clear_c, ctr_en_c, expired;

    assign accept_c    = req_valid && req_ready_q;
    assign ctr_clear_c = (state_q != ST_WAIT);
    assign ctr_en_c    = (state_q == ST_WAIT);

    lsu_timeout_ctr #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout_ctr (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (ctr_clear_c),
        .enable  (ctr_en_c),
        .expired (expired)
    );

    // Next-state, request capture and exception decision
    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        rdata_d = rdata_q;
        exc_d   = 1'b0;
        cause_d = EXC_NONE;
        unique case (state_q)
            ST_IDLE: begin
                if (accept_c) begin
                    req_d.op    = lsu_op_e'(req_op);
                    req_d.addr  = req_addr;
                    req_d.wdata = req_wdata;
                    req_d.rd    = req_rd;
                    if (!op_is_legal(lsu_op_e'(req_op))) begin
                        exc_d   = 1'b1;
                        cause_d = EXC_ILLEGAL;
                    end else if (req_addr[1:0] != 2'b00) begin
                        exc_d   = 1'b1;
                        cause_d = EXC_MISALIGN;
                    end else begin
                        state_d = ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                if (mem_gnt) begin
                    state_d = (req_q.op == OP_SW) ? ST_IDLE : ST_WAIT;
                end
            end
            ST_WAIT: begin
                // a response arriving on the last allowed cycle still completes the load
                if (mem_rvalid) begin
                    rdata_d = mem_rdata;
                    state_d = ST_RESP;
                end else if (expired) begin
                    exc_d   = 1'b1;
                    cause_d = EXC_TIMEOUT;
                    state_d = ST_IDLE;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs, all derived from the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            req_q       <= '0;
            rdata_q     <= '0;
            req_ready_q <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            wb_valid_q  <= 1'b0;
            wb_rd_q     <= '0;
            wb_data_q   <= '0;
            exc_valid_q <= 1'b0;
            exc_cause_q <= EXC_NONE;
        end else begin
            state_q     <= state_d;
            req_q       <= req_d;
            rdata_q     <= rdata_d;
            req_ready_q <= (state_d == ST_IDLE);
            mem_req_q   <= (state_d == ST_REQ);
            mem_we_q    <= (state_d == ST_REQ) && (req_d.op == OP_SW);
            mem_addr_q  <= (state_d == ST_REQ) ? req_d.addr : '0;
            mem_wdata_q <= ((state_d == ST_REQ) && (req_d.op == OP_SW)) ? req_d.wdata : '0;
            wb_valid_q  <= (state_d == ST_RESP) && (req_d.rd != '0);
            wb_rd_q     <= (state_d == ST_RESP) ? req_d.rd : '0;
            wb_data_q   <= (state_d == ST_RESP) ? rdata_d : '0;
            exc_valid_q <= exc_d;
            exc_cause_q <= cause_d;
        end
    end

    assign req_ready = req_ready_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign wb_valid  = wb_valid_q;
    assign wb_rd     = wb_rd_q;
    assign wb_data   = wb_data_q;
    assign exc_valid = exc_valid_q;
    assign exc_cause = exc_cause_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: table of ops plus reset/timeout sequences, scoreboarded results.
module tb_load_store_unit;

    localparam int unsigned TMO = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [1:0]  req_op = 2'b00;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [4:0]  req_rd = '0;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_gnt = 1'b0;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        exc_valid;
    logic [1:0]  exc_cause;

    load_store_unit #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .exc_valid(exc_valid), .exc_cause(exc_cause)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [4:0]  rd;
        logic [31:0] rdata;
        int          gnt_dly;
        int          rv_dly;
        logic        no_rv;
        logic        exp_exc;
        logic [1:0]  exp_cause;
    } vec_t;

    typedef struct {
        logic        is_exc;
        logic [1:0]  cause;
        logic [4:0]  rd;
        logic [31:0] data;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   failures = 0;
    int   cur_vec = -1;
    vec_t vecs[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s vec=%0d actual=0x%08h required=0x%08h t=%0t", name, cur_vec, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_req_ready"}, 32'(req_ready), 32'd0);
        chk({tag, "_mem_req"},   32'(mem_req),   32'd0);
        chk({tag, "_mem_we"},    32'(mem_we),    32'd0);
        chk({tag, "_mem_addr"},  mem_addr,       32'd0);
        chk({tag, "_mem_wdata"}, mem_wdata,      32'd0);
        chk({tag, "_wb_valid"},  32'(wb_valid),  32'd0);
        chk({tag, "_wb_rd"},     32'(wb_rd),     32'd0);
        chk({tag, "_wb_data"},   wb_data,        32'd0);
        chk({tag, "_exc_valid"}, 32'(exc_valid), 32'd0);
        chk({tag, "_exc_cause"}, 32'(exc_cause), 32'd0);
    endtask

    // Scoreboard: every wb/exc pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && (wb_valid || exc_valid)) begin
            if (sb_q.size() == 0) begin
                chk("sb_unexpected_event", {30'd0, wb_valid, exc_valid}, 32'd0);
            end else begin
                e = sb_q.pop_front();
                chk("sb_kind_exc", 32'(exc_valid), 32'(e.is_exc));
                chk("sb_kind_wb", 32'(wb_valid), 32'(!e.is_exc));
                if (e.is_exc) begin
                    chk("sb_exc_cause", 32'(exc_cause), 32'(e.cause));
                end else begin
                    chk("sb_wb_rd", 32'(wb_rd), 32'(e.rd));
                    chk("sb_wb_data", wb_data, e.data);
                end
            end
        end
    end

    // Drive one op from IDLE (called just after a clock edge) and play the memory side
    task automatic run_op(input vec_t v);
        exp_t e;
        if (v.exp_exc) begin
            e = '{is_exc: 1'b1, cause: v.exp_cause, rd: 5'd0, data: 32'd0};
            sb_q.push_back(e);
        end else if (v.op == 2'b01 && v.rd != 5'd0) begin
            e = '{is_exc: 1'b0, cause: 2'b00, rd: v.rd, data: v.rdata};
            sb_q.push_back(e);
        end
        chk("pre_req_ready", 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_op    = v.op;
        req_addr  = v.addr;
        req_wdata = v.wdata;
        req_rd    = v.rd;
        tick();
        req_valid = 1'b0;
        req_op    = 2'($urandom);
        req_addr  = $urandom;
        req_wdata = $urandom;
        req_rd    = 5'($urandom);
        if (v.exp_exc && !v.no_rv) begin
            chk("exc_mem_req", 32'(mem_req), 32'd0);
            chk("exc_valid", 32'(exc_valid), 32'd1);
            chk("exc_cause", 32'(exc_cause), 32'(v.exp_cause));
            chk("exc_req_ready", 32'(req_ready), 32'd1);
            tick();
            chk("exc_mem_req2", 32'(mem_req), 32'd0);
            chk("exc_pulse_end", 32'(exc_valid), 32'd0);
            return;
        end
        for (int k = 0; k <= v.gnt_dly; k++) begin
            chk("req_mem_req", 32'(mem_req), 32'd1);
            chk("req_mem_addr", mem_addr, v.addr);
            chk("req_mem_we", 32'(mem_we), 32'(v.op == 2'b10));
            if (v.op == 2'b10) chk("req_mem_wdata", mem_wdata, v.wdata);
            chk("req_ready_busy", 32'(req_ready), 32'd0);
            mem_gnt = (k == v.gnt_dly);
            tick();
        end
        mem_gnt = 1'b0;
        if (v.op == 2'b10) begin
            chk("sw_done_ready", 32'(req_ready), 32'd1);
            chk("sw_done_mem_req", 32'(mem_req), 32'd0);
            chk("sw_no_wb", 32'(wb_valid), 32'd0);
            return;
        end
        if (v.no_rv) begin
            for (int k = 0; k < int'(TMO); k++) begin
                chk("wait_no_exc", 32'(exc_valid), 32'd0);
                chk("wait_not_ready", 32'(req_ready), 32'd0);
                tick();
            end
            chk("tmo_exc_valid", 32'(exc_valid), 32'd1);
            chk("tmo_exc_cause", 32'(exc_cause), 32'd3);
            chk("tmo_req_ready", 32'(req_ready), 32'd1);
            return;
        end
        for (int k = 0; k <= v.rv_dly; k++) begin
            chk("wait_no_wb", 32'(wb_valid), 32'd0);
            mem_rvalid = (k == v.rv_dly);
            mem_rdata  = (k == v.rv_dly) ? v.rdata : $urandom;
            tick();
        end
        mem_rvalid = 1'b0;
        mem_rdata  = $urandom;
        chk("resp_wb_valid", 32'(wb_valid), 32'(v.rd != 5'd0));
        if (v.rd != 5'd0) begin
            chk("resp_wb_rd", 32'(wb_rd), 32'(v.rd));
            chk("resp_wb_data", wb_data, v.rdata);
        end
        tick();
        chk("resp_pulse_end", 32'(wb_valid), 32'd0);
        chk("resp_req_ready", 32'(req_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        //          op     addr          wdata         rd     rdata         gnt rv  no_rv exc   cause
        vecs[0]  = '{2'b10, 32'h0000_0100, 32'hDEAD_BEEF, 5'd0,  32'h0,        3,  0, 1'b0, 1'b0, 2'b00};
        vecs[1]  = '{2'b01, 32'h0000_0200, 32'h0,         5'd5,  32'h1234_5678, 0,  2, 1'b0, 1'b0, 2'b00};
        vecs[2]  = '{2'b01, 32'h0000_0202, 32'h0,         5'd7,  32'h0,        0,  0, 1'b0, 1'b1, 2'b01};
        vecs[3]  = '{2'b11, 32'h0000_0003, 32'h0,         5'd4,  32'h0,        0,  0, 1'b0, 1'b1, 2'b10};
        vecs[4]  = '{2'b01, 32'h0000_0040, 32'h0,         5'd0,  32'hCAFE_F00D, 0,  0, 1'b0, 1'b0, 2'b00};
        vecs[5]  = '{2'b10, 32'h0000_0004, 32'h0102_0304, 5'd0,  32'h0,        0,  0, 1'b0, 1'b0, 2'b00};
        vecs[6]  = '{2'b01, 32'h0000_0008, 32'h0,         5'd31, 32'hA5A5_5A5A, 0,  0, 1'b0, 1'b0, 2'b00};
        vecs[7]  = '{2'b01, 32'h0000_000C, 32'h0,         5'd1,  32'h8000_0001, 1,  3, 1'b0, 1'b0, 2'b00};
        vecs[8]  = '{2'b00, 32'h0000_0010, 32'h0,         5'd2,  32'h0,        0,  0, 1'b0, 1'b1, 2'b10};
        vecs[9]  = '{2'b10, 32'h0000_0101, 32'h1111_2222, 5'd0,  32'h0,        0,  0, 1'b0, 1'b1, 2'b01};
        vecs[10] = '{2'b00, 32'h0000_0001, 32'h0,         5'd3,  32'h0,        0,  0, 1'b0, 1'b1, 2'b10};
        vecs[11] = '{2'b10, 32'hFFFF_FFFC, 32'h0,         5'd0,  32'h0,        2,  0, 1'b0, 1'b0, 2'b00};
        vecs[12] = '{2'b01, 32'h0000_0300, 32'h0,         5'd9,  32'h0,        1,  0, 1'b1, 1'b1, 2'b11};

        // Reset state, then first edge after release brings req_ready up
        tick();
        tick();
        chk_all_zero("rst");
        rst_n = 1'b1;
        chk("rel_ready_before_edge", 32'(req_ready), 32'd0);
        tick();
        chk("rel_ready_first_edge", 32'(req_ready), 32'd1);

        for (int i = 0; i < 13; i++) begin
            cur_vec = i;
            run_op(vecs[i]);
        end
        cur_vec = 100;

        // Stray rvalid after the timeout must be ignored
        for (int k = 0; k < 3; k++) begin
            mem_rvalid = 1'b1;
            mem_rdata  = $urandom;
            tick();
            chk("stray_no_wb", 32'(wb_valid), 32'd0);
            chk("stray_ready", 32'(req_ready), 32'd1);
            chk("stray_no_mem_req", 32'(mem_req), 32'd0);
        end
        mem_rvalid = 1'b0;

        // Reset while in REQ drops mem_req asynchronously
        cur_vec = 101;
        req_valid = 1'b1; req_op = 2'b01; req_addr = 32'h0000_0400; req_rd = 5'd3;
        tick();
        req_valid = 1'b0;
        chk("rq_mem_req_before", 32'(mem_req), 32'd1);
        #3 rst_n = 1'b0;
        #1 chk_all_zero("rst_in_req");
        tick();
        rst_n = 1'b1;
        chk("rq_ready_in_release", 32'(req_ready), 32'd0);
        tick();
        chk("rq_ready_after", 32'(req_ready), 32'd1);

        // Reset while in WAIT abandons the load; a stray rvalid during reset does nothing
        cur_vec = 102;
        req_valid = 1'b1; req_op = 2'b01; req_addr = 32'h0000_0500; req_rd = 5'd6;
        tick();
        req_valid = 1'b0;
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        chk("rw_in_wait_not_ready", 32'(req_ready), 32'd0);
        #3 rst_n = 1'b0;
        #1 chk_all_zero("rst_in_wait");
        mem_rvalid = 1'b1; mem_rdata = 32'hBAD0_BAD0;
        tick();
        tick();
        chk_all_zero("rst_held");
        mem_rvalid = 1'b0;
        rst_n = 1'b1;
        tick();
        chk("rw_ready_after", 32'(req_ready), 32'd1);
        chk("rw_no_wb", 32'(wb_valid), 32'd0);

        cur_vec = 103;
        run_op('{2'b01, 32'h0000_0600, 32'h0, 5'd12, 32'h0BAD_F00D, 0, 1, 1'b0, 1'b0, 2'b00});

        tick();
        tick();
        chk("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
